// File: rtl/alu_pkg.sv
// Package for the ALU result stage.
// Holds the flag bit positions, default datapath sizes and the width of the
// per-entry flag storage.
// Optional feature macro: PARITY_FLAG_EN. When it is defined, the parity (P) flag
// is stored with each entry. When it is not defined, only {C,N,Z} are stored.
package alu_pkg;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_P = 3;
    localparam int FLAG_W = 4;

    localparam int DATA_W_DEF = 8;
    localparam int DEST_W_DEF = 3;
    localparam int DEPTH_DEF  = 2;

`ifdef PARITY_FLAG_EN
    localparam int STORE_W = 4;
`else
    localparam int STORE_W = 3;
`endif

endpackage

// File: rtl/alu_result_stage_if.sv
// Handshake bundle between the ALU function units, the result stage and the
// writeback side.
//   in_*  : producer -> stage (valid/ready), with result, carry, destination and
//           the update-flags request
//   out_* : stage -> writeback (valid/ready), with head result and destination
// Modports:
//   slave  : the result stage itself
//   master : the environment that drives ALU results and consumes writebacks
interface alu_result_stage_if
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEST_W = DEST_W_DEF
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_result;
    logic              in_carry;
    logic [DEST_W-1:0] in_dest;
    logic              in_upd_flags;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic [DEST_W-1:0] out_dest;

    modport slave (
        input  in_valid, in_result, in_carry, in_dest, in_upd_flags, out_ready,
        output in_ready, out_valid, out_result, out_dest
    );

    modport master (
        output in_valid, in_result, in_carry, in_dest, in_upd_flags, out_ready,
        input  in_ready, out_valid, out_result, out_dest
    );
endinterface

// File: rtl/alu_flag_gen.sv
// Combinational flag generator, shared by the ALU stages.
// Ports:
//   result_i : ALU result
//   carry_i  : carry-out from the function unit
//   flags_o  : {P,C,N,Z} when PARITY_FLAG_EN is defined, otherwise {C,N,Z}
// Optional feature macro: PARITY_FLAG_EN. It adds the even-parity flag.
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
)
(
    input  logic [DATA_W-1:0]  result_i,
    input  logic               carry_i,
    output logic [STORE_W-1:0] flags_o
);

`ifdef PARITY_FLAG_EN
    // Returns 1 when the word has an even number of set bits.
    function automatic logic even_parity(input logic [DATA_W-1:0] word);
        return ~^word;
    endfunction
`endif

    // Derive the status flags from the result and the carry.
    always_comb begin
        flags_o         = '0;
        flags_o[FLAG_Z] = (result_i == '0);
        flags_o[FLAG_N] = result_i[DATA_W-1];
        flags_o[FLAG_C] = carry_i;
`ifdef PARITY_FLAG_EN
        flags_o[FLAG_P] = even_parity(result_i);
`endif
    end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage.
// Captures ALU results and computes their flags on enqueue. Buffers the results
// in a DEPTH-entry FIFO toward register-file writeback. Commits the stored flags
// to the architectural flag register when an entry retires.
// Ports:
//   clk     : rising-edge clock
//   rst     : synchronous, active-high reset
//   flush   : discard all buffered entries. flags_q holds.
//   bus     : alu_result_stage_if.slave (in_* enqueue, out_* writeback)
//   flags_q : architectural flags {P,C,N,Z}
// Optional feature macro: PARITY_FLAG_EN. Without it, flags_q[3] is tied to 0 and
// no parity logic or storage is built.
// Priority: rst > flush > push/pop.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEST_W = DEST_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    alu_result_stage_if.slave  bus,
    output logic [FLAG_W-1:0]  flags_q
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [CNT_W-1:0]   count_q,   count_d;
    logic [PTR_W-1:0]   rd_ptr_q,  rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q,  wr_ptr_d;
    logic [STORE_W-1:0] flag_reg_q, flag_reg_d;

    logic [DATA_W-1:0]  mem_result_q [DEPTH];
    logic [DATA_W-1:0]  mem_result_d [DEPTH];
    logic [DEST_W-1:0]  mem_dest_q   [DEPTH];
    logic [DEST_W-1:0]  mem_dest_d   [DEPTH];
    logic [STORE_W-1:0] mem_flags_q  [DEPTH];
    logic [STORE_W-1:0] mem_flags_d  [DEPTH];
    logic               mem_upd_q    [DEPTH];
    logic               mem_upd_d    [DEPTH];

    logic               in_ready_s;
    logic               out_valid_s;
    logic               push_s;
    logic               pop_s;
    logic [STORE_W-1:0] new_flags_s;

    alu_flag_gen #(.DATA_W(DATA_W)) u_flag_gen (
        .result_i (bus.in_result),
        .carry_i  (bus.in_carry),
        .flags_o  (new_flags_s)
    );

    // Handshake status. It depends only on the registered count, so in_ready never
    // follows out_ready combinationally.
    always_comb begin
        in_ready_s  = (count_q != CNT_W'(DEPTH));
        out_valid_s = (count_q != '0);
        push_s      = bus.in_valid & in_ready_s;
        pop_s       = out_valid_s & bus.out_ready;
    end

    // Drive the head entry onto the writeback side. The head is forced to zero when the FIFO is empty.
    always_comb begin
        bus.in_ready  = in_ready_s;
        bus.out_valid = out_valid_s;
        if (out_valid_s) begin
            bus.out_result = mem_result_q[rd_ptr_q];
            bus.out_dest   = mem_dest_q[rd_ptr_q];
        end else begin
            bus.out_result = '0;
            bus.out_dest   = '0;
        end
    end

    // Next-state for the pointers, count, storage and flag register.
    // Flush discards the push and suppresses the flag commit of any concurrent pop.
    always_comb begin
        count_d      = count_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        flag_reg_d   = flag_reg_q;
        mem_result_d = mem_result_q;
        mem_dest_d   = mem_dest_q;
        mem_flags_d  = mem_flags_q;
        mem_upd_d    = mem_upd_q;
        if (flush) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push_s) begin
                mem_result_d[wr_ptr_q] = bus.in_result;
                mem_dest_d[wr_ptr_q]   = bus.in_dest;
                mem_flags_d[wr_ptr_q]  = new_flags_s;
                mem_upd_d[wr_ptr_q]    = bus.in_upd_flags;
                wr_ptr_d               = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
                if (mem_upd_q[rd_ptr_q]) begin
                    flag_reg_d = mem_flags_q[rd_ptr_q];
                end else begin
                    flag_reg_d = flag_reg_q;
                end
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state and the architectural flags. Synchronous reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            flag_reg_q <= '0;
        end else begin
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            flag_reg_q <= flag_reg_d;
        end
    end

    // Entry payload storage. It needs no reset because out_valid gates every read.
    always_ff @(posedge clk) begin
        mem_result_q <= mem_result_d;
        mem_dest_q   <= mem_dest_d;
        mem_flags_q  <= mem_flags_d;
        mem_upd_q    <= mem_upd_d;
    end

`ifdef PARITY_FLAG_EN
    assign flags_q = flag_reg_q;
`else
    assign flags_q = {1'b0, flag_reg_q};
`endif

endmodule
